// File: rtl/pipe_latch.sv
// Two-entry skid latch between pipeline stages: MAIN drives the outputs and SKID
// absorbs the one extra beat that arrives while downstream stalls.
module pipe_latch #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5,
    parameter int CTRL_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] oIn,
    input  logic [DATA_W-1:0] dIn,
    input  logic [RD_W-1:0]   rdIn,
    input  logic [CTRL_W-1:0] ctrlIn,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] oOut,
    output logic [DATA_W-1:0] dOut,
    output logic [RD_W-1:0]   rdOut,
    output logic [CTRL_W-1:0] ctrlOut,
    output logic [1:0]        occupancy
);

    // State encoding equals the number of held beats, so occupancy doubles as
    // the observable FSM state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } stateT;

    typedef struct packed {
        logic [DATA_W-1:0] o;
        logic [DATA_W-1:0] d;
        logic [RD_W-1:0]   rd;
        logic [CTRL_W-1:0] ctrl;
    } beatT;

    stateT state;
    beatT  mainQ;
    beatT  skidQ;
    beatT  inBeat;
    logic  accept;
    logic  emit;

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high; inReady never looks at outReady, which is what the SKID
    // entry is for.
    assign inReady   = (state != SKID) && !reset;
    assign outValid  = (state != EMPTY);
    assign occupancy = state;
    assign accept    = inValid && inReady;
    assign emit      = outValid && outReady;

    assign inBeat = '{o: oIn, d: dIn, rd: rdIn, ctrl: ctrlIn};

    // Control fields read zero in a bubble so a stale rd/wReg cannot leak
    // downstream; the data words simply keep their last value.
    assign oOut    = mainQ.o;
    assign dOut    = mainQ.d;
    assign rdOut   = outValid ? mainQ.rd : '0;
    assign ctrlOut = outValid ? mainQ.ctrl : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        mainQ <= inBeat;
                        state <= FULL;
                    end
                end
                FULL: begin
                    if (accept && emit) begin
                        mainQ <= inBeat;
                    end else if (accept) begin
                        skidQ <= inBeat;
                        state <= SKID;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                SKID: begin
                    if (emit) begin
                        mainQ <= skidQ;
                        state <= FULL;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_latch.sv
// Bench for pipe_latch: default-width and narrow instances run in lockstep, with a
// queue model of held beats checked every cycle.
module tb_pipe_latch;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [31:0] oIn;
    logic [31:0] dIn;
    logic [4:0]  rdIn;
    logic [1:0]  ctrlIn;
    logic        flush;
    logic        outReady;

    logic        inReadyA, outValidA;
    logic [31:0] oOutA, dOutA;
    logic [4:0]  rdOutA;
    logic [1:0]  ctrlOutA;
    logic [1:0]  occA;

    logic [7:0]  oInB, dInB;
    logic [2:0]  rdInB;
    logic [3:0]  ctrlInB;
    logic        inReadyB, outValidB;
    logic [7:0]  oOutB, dOutB;
    logic [2:0]  rdOutB;
    logic [3:0]  ctrlOutB;
    logic [1:0]  occB;

    assign oInB    = oIn[7:0];
    assign dInB    = dIn[7:0];
    assign rdInB   = rdIn[2:0];
    assign ctrlInB = {~ctrlIn, ctrlIn};

    pipe_latch dutA (
        .clock(clk), .reset(reset), .inValid(inValid), .inReady(inReadyA),
        .oIn(oIn), .dIn(dIn), .rdIn(rdIn), .ctrlIn(ctrlIn), .flush(flush),
        .outValid(outValidA), .outReady(outReady), .oOut(oOutA), .dOut(dOutA),
        .rdOut(rdOutA), .ctrlOut(ctrlOutA), .occupancy(occA)
    );

    pipe_latch #(.DATA_W(8), .RD_W(3), .CTRL_W(4)) dutB (
        .clock(clk), .reset(reset), .inValid(inValid), .inReady(inReadyB),
        .oIn(oInB), .dIn(dInB), .rdIn(rdInB), .ctrlIn(ctrlInB), .flush(flush),
        .outValid(outValidB), .outReady(outReady), .oOut(oOutB), .dOut(dOutB),
        .rdOut(rdOutB), .ctrlOut(ctrlOutB), .occupancy(occB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    logic [70:0] expA[$];
    logic [22:0] expB[$];
    logic [63:0] lastA;
    logic [15:0] lastB;
    logic        known;
    logic        monOn;
    logic        accM, emitM;
    int          n;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the queue holds exactly the beats the latch should be holding.
    always @(negedge clk) begin
        if (monOn) begin
            n     = expA.size();
            accM  = inValid && (n < 2) && !reset && !flush;
            emitM = (n > 0) && outReady && !reset && !flush;
            check("inReadyA", 128'(inReadyA), 128'((n != 2) && !reset));
            check("inReadyB", 128'(inReadyB), 128'((n != 2) && !reset));
            check("outValidA", 128'(outValidA), 128'(n != 0));
            check("outValidB", 128'(outValidB), 128'(n != 0));
            check("occupancyA", 128'(occA), 128'(n));
            check("occupancyB", 128'(occB), 128'(n));
            if (n > 0) begin
                check("beatA", 128'({oOutA, dOutA, rdOutA, ctrlOutA}), 128'(expA[0]));
                check("beatB", 128'({oOutB, dOutB, rdOutB, ctrlOutB}), 128'(expB[0]));
            end else begin
                check("bubbleCtrlA", 128'({rdOutA, ctrlOutA}), 128'(0));
                check("bubbleCtrlB", 128'({rdOutB, ctrlOutB}), 128'(0));
                if (known) begin
                    check("bubbleDataA", 128'({oOutA, dOutA}), 128'(lastA));
                    check("bubbleDataB", 128'({oOutB, dOutB}), 128'(lastB));
                end
            end
            if (reset) begin
                expA.delete(); expB.delete();
                lastA = '0; lastB = '0; known = 1'b1;
            end else if (flush) begin
                expA.delete(); expB.delete();
                known = 1'b0;
            end else begin
                if (emitM) begin
                    lastA = expA[0][70:7];
                    lastB = expB[0][22:7];
                    known = 1'b1;
                    void'(expA.pop_front());
                    void'(expB.pop_front());
                end
                if (accM) begin
                    expA.push_back({oIn, dIn, rdIn, ctrlIn});
                    expB.push_back({oInB, dInB, rdInB, ctrlInB});
                end
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] o, input logic [31:0] d,
                        input logic [4:0] rd, input logic [1:0] c,
                        input logic ordy, input logic fl);
        inValid  = v;
        oIn      = o;
        dIn      = d;
        rdIn     = rd;
        ctrlIn   = c;
        outReady = ordy;
        flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        monOn = 1'b0; known = 1'b1; lastA = '0; lastB = '0;
        reset = 1'b1; inValid = 1'b0; oIn = '0; dIn = '0; rdIn = '0;
        ctrlIn = '0; flush = 1'b0; outReady = 1'b0;
        @(posedge clk);
        #1;
        monOn = 1'b1;
        step(1'b1, 32'h99, 32'h99, 5'd1, 2'd1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Pass-through at full rate.
        for (int i = 1; i <= 8; i++)
            step(1'b1, 32'(i), 32'(i * 16 + 3), 5'(i), 2'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Back-pressure: A and B held, C stalled, then released.
        step(1'b1, 32'h11, 32'hA1, 5'd1, 2'd1, 1'b0, 1'b0);
        step(1'b1, 32'h22, 32'hA2, 5'd2, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 32'h33, 32'hA3, 5'd3, 2'd3, 1'b0, 1'b0);
        step(1'b1, 32'h33, 32'hA3, 5'd3, 2'd3, 1'b1, 1'b0);
        step(1'b1, 32'h33, 32'hA3, 5'd3, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Flush with both entries occupied and a new beat on offer.
        step(1'b1, 32'h44, 32'hB4, 5'd4, 2'd1, 1'b0, 1'b0);
        step(1'b1, 32'h55, 32'hB5, 5'd5, 2'd2, 1'b0, 1'b0);
        step(1'b1, 32'h66, 32'hB6, 5'd6, 2'd3, 1'b1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Bubble gating after a single beat.
        step(1'b1, 32'hABCD, 32'h1234, 5'd5, 2'b11, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Reset while FULL with a beat on offer.
        step(1'b1, 32'h77, 32'hC7, 5'd7, 2'd1, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b1, 32'h88, 32'hC8, 5'd8, 2'd2, 1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 80; i++)
            step(1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom),
                 5'($urandom), 2'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0));
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b1, 1'b0);

        check("drainedA", 128'(expA.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
